// File: rtl/noc_tg_top.sv
// Traffic harness for a ROWS x COLS mesh. Each node has a packet generator
// on its local injection port and a flit checker on its ejection port.
// A start pulse launches NUM_PKTS packets per node. The harness reports done
// when every tail has come back, or a sticky err on any bad flit or timeout.
//
// Generator FSM (one per node)
//   state  | meaning
//   IDLE   | waiting for an accepted start
//   GAP    | counting down inter-packet idle cycles; destination latched on exit
//   SEND   | presenting flits of the current packet, advancing on tx_ready
//   FIN    | all packets sent; waits for the run to end
`timescale 1ns/1ps
module noc_tg_top #(
    parameter int          ROWS      = 2,
    parameter int          COLS      = 2,
    parameter int          FLIT_W    = 32,
    parameter int          PKT_LEN   = 4,
    parameter int          NUM_PKTS  = 16,
    parameter int          TIMEOUT   = 4096,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         N         = ROWS * COLS,
    localparam int         ID_W      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ID_W-1:0]     fixed_dst,
    input  logic [7:0]          inj_gap,
    output logic [N-1:0]        tx_valid,
    output logic [N*FLIT_W-1:0] tx_data,
    input  logic [N-1:0]        tx_ready,
    input  logic [N-1:0]        rx_valid,
    input  logic [N*FLIT_W-1:0] rx_data,
    output logic [N-1:0]        rx_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [15:0]         tx_pkts,
    output logic [15:0]         rx_pkts
);

    localparam int PC_W   = $clog2(NUM_PKTS + 1);
    localparam int FI_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int TOT    = N * NUM_PKTS;
    localparam int SRC_HI = FLIT_W - 2;
    localparam int DST_HI = FLIT_W - 2 - ID_W;
    localparam int SEQ_HI = FLIT_W - 2 - 2 * ID_W;

    typedef enum logic [1:0] {G_IDLE, G_GAP, G_SEND, G_FIN} gen_state_t;

    gen_state_t        gen_state [N];
    gen_state_t        gen_next  [N];
    logic [7:0]        gap_cnt   [N];
    logic [FI_W-1:0]   flit_idx  [N];
    logic [PC_W-1:0]   pkts_sent [N];
    logic [7:0]        seq       [N];
    logic [ID_W-1:0]   dst_q     [N];
    logic [ID_W-1:0]   dst_sel   [N];
    logic [15:0]       lfsr      [N];
    logic [FI_W-1:0]   rx_cnt    [N];
    logic [7:0]        gap_lat;
    logic [TO_W-1:0]   tmo_cnt;
    logic [N-1:0]      tail_out;
    logic [N-1:0]      tail_fire;
    logic [N-1:0]      rx_tail;
    logic              start_acc;
    logic              all_fin;
    logic              chk_err;
    logic              tmo_hit;
    logic [16:0]       tx_sum;
    logic [16:0]       rx_sum;
    logic              rx_unused_bits;

    function automatic logic [15:0] seed_of(input int idx);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(idx);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign start_acc      = start && !busy;
    assign rx_unused_bits = ^rx_data;

    // Generator state registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) gen_state[i] <= G_IDLE;
            else      gen_state[i] <= gen_next[i];
        end
    end

    // Generator next-state logic; a start always restarts, end of run parks in IDLE
    always_comb begin
        for (int i = 0; i < N; i++) begin
            gen_next[i] = gen_state[i];
            if (start_acc) begin
                gen_next[i] = G_GAP;
            end else if (gen_state[i] != G_IDLE && !busy) begin
                gen_next[i] = G_IDLE;
            end else begin
                case (gen_state[i])
                    G_GAP:  if (gap_cnt[i] == 8'd0) gen_next[i] = G_SEND;
                    G_SEND: if (tail_fire[i])
                                gen_next[i] = (pkts_sent[i] == PC_W'(NUM_PKTS - 1)) ? G_FIN : G_GAP;
                    default: ;
                endcase
            end
        end
    end

    // Generator outputs: flit valid and flit contents per node
    always_comb begin
        logic [FLIT_W-1:0] f;
        tx_valid = '0;
        tx_data  = '0;
        for (int i = 0; i < N; i++) begin
            tail_out[i]   = (flit_idx[i] == FI_W'(PKT_LEN - 1));
            tx_valid[i]   = (gen_state[i] == G_SEND) && busy;
            f             = '0;
            f[FLIT_W-1]   = tail_out[i];
            f[SRC_HI -: ID_W] = ID_W'(i);
            f[DST_HI -: ID_W] = dst_q[i];
            f[SEQ_HI -: 8]    = seq[i];
            tx_data[i*FLIT_W +: FLIT_W] = f;
        end
    end

    // Accepted tail flits, one bit per node
    always_comb begin
        for (int i = 0; i < N; i++) begin
            tail_fire[i] = tx_valid[i] && tx_ready[i] && tail_out[i];
        end
    end

    // Destination candidate per node for the next packet
    always_comb begin
        logic [ID_W-1:0] r;
        logic [ID_W-1:0] rm;
        logic [ID_W-1:0] nb;
        for (int i = 0; i < N; i++) begin
            r  = lfsr[i][ID_W-1:0];
            rm = r;
            if (32'(r) >= 32'(N)) rm = r - ID_W'(N);
            nb = ID_W'((i + 1) % N);
            case (mode)
                2'd1:    dst_sel[i] = fixed_dst;
                2'd2:    dst_sel[i] = nb;
                default: dst_sel[i] = (rm == ID_W'(i)) ? nb : rm;
            endcase
        end
    end

    // Generator datapath: gap timer, flit index, packet/seq counters, LFSR
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst) begin
                gap_cnt[i]   <= 8'd0;
                flit_idx[i]  <= '0;
                pkts_sent[i] <= '0;
                seq[i]       <= 8'd0;
                dst_q[i]     <= '0;
                lfsr[i]      <= seed_of(i);
            end else if (start_acc) begin
                gap_cnt[i]   <= inj_gap;
                flit_idx[i]  <= '0;
                pkts_sent[i] <= '0;
            end else if (busy) begin
                case (gen_state[i])
                    G_GAP: begin
                        if (gap_cnt[i] == 8'd0) begin
                            dst_q[i] <= dst_sel[i];
                            if (mode != 2'd1 && mode != 2'd2) lfsr[i] <= lfsr_step(lfsr[i]);
                        end else begin
                            gap_cnt[i] <= gap_cnt[i] - 8'd1;
                        end
                    end
                    G_SEND: begin
                        if (tx_valid[i] && tx_ready[i]) begin
                            if (tail_out[i]) begin
                                flit_idx[i]  <= '0;
                                pkts_sent[i] <= pkts_sent[i] + PC_W'(1);
                                seq[i]       <= seq[i] + 8'd1;
                                gap_cnt[i]   <= gap_lat;
                            end else begin
                                flit_idx[i]  <= flit_idx[i] + FI_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Inter-packet gap captured once per run
    always_ff @(posedge clk) begin
        if (!rst)           gap_lat <= 8'd0;
        else if (start_acc) gap_lat <= inj_gap;
    end

    // Checker: flag misrouted flits, bad sources and wrong packet lengths
    always_comb begin
        logic [FLIT_W-1:0] fl;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   dst;
        chk_err = 1'b0;
        rx_tail = '0;
        for (int i = 0; i < N; i++) begin
            fl  = rx_data[i*FLIT_W +: FLIT_W];
            src = fl[SRC_HI -: ID_W];
            dst = fl[DST_HI -: ID_W];
            rx_tail[i] = rx_valid[i] && fl[FLIT_W-1];
            if (rx_valid[i]) begin
                if (dst != ID_W'(i) || 32'(src) >= 32'(N)) chk_err = 1'b1;
                if (fl[FLIT_W-1] != (rx_cnt[i] == FI_W'(PKT_LEN - 1))) chk_err = 1'b1;
            end
        end
    end

    // Checker per-packet flit position
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst || start_acc) begin
                rx_cnt[i] <= '0;
            end else if (rx_valid[i]) begin
                if (rx_tail[i])                              rx_cnt[i] <= '0;
                else if (rx_cnt[i] != FI_W'(PKT_LEN - 1))    rx_cnt[i] <= rx_cnt[i] + FI_W'(1);
            end
        end
    end

    // Tail popcounts added to the packet totals, and run completion inputs
    always_comb begin
        tx_sum  = {1'b0, tx_pkts};
        rx_sum  = {1'b0, rx_pkts};
        all_fin = 1'b1;
        for (int i = 0; i < N; i++) begin
            tx_sum = tx_sum + 17'(tail_fire[i]);
            rx_sum = rx_sum + 17'(rx_tail[i]);
            if (gen_state[i] != G_FIN) all_fin = 1'b0;
        end
        tmo_hit = busy && !(|rx_valid) && (tmo_cnt == '0);
    end

    // Run control: busy/done/err, saturating packet counters, idle timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tx_pkts  <= 16'd0;
            rx_pkts  <= 16'd0;
            tmo_cnt  <= '0;
            rx_ready <= '0;
        end else begin
            rx_ready <= '1;
            if (start_acc) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                err     <= 1'b0;
                tx_pkts <= 16'd0;
                rx_pkts <= 16'd0;
                tmo_cnt <= TO_W'(TIMEOUT - 1);
            end else begin
                tx_pkts <= tx_sum[16] ? 16'hFFFF : tx_sum[15:0];
                rx_pkts <= rx_sum[16] ? 16'hFFFF : rx_sum[15:0];
                if (|rx_valid)                    tmo_cnt <= TO_W'(TIMEOUT - 1);
                else if (busy && tmo_cnt != '0)   tmo_cnt <= tmo_cnt - TO_W'(1);
                if (chk_err || tmo_hit) begin
                    err  <= 1'b1;
                    busy <= 1'b0;
                end else if (busy && all_fin && rx_pkts == 16'(TOT)) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_tg_top.sv
// Bench for noc_tg_top on a 2x2 mesh with an ideal loopback network model
// (wormhole-locked per destination, optional random backpressure).
`timescale 1ns/1ps
module tb_noc_tg_top;

    localparam int N  = 4;
    localparam int FW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [1:0]      fixed_dst = 2'd0;
    logic [7:0]      inj_gap = 8'd0;
    logic [N-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
    logic [N*FW-1:0] tx_data, rx_data;
    logic            busy, done, err;
    logic [15:0]     tx_pkts, rx_pkts;

    always #5 clk = ~clk;

    noc_tg_top #(
        .ROWS(2), .COLS(2), .FLIT_W(32), .PKT_LEN(4), .NUM_PKTS(16),
        .TIMEOUT(4096), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_dst(fixed_dst),
        .inj_gap(inj_gap), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err), .tx_pkts(tx_pkts), .rx_pkts(rx_pkts)
    );

    // Network model controls
    logic            net_en = 1'b0;
    logic            bp_en  = 1'b0;
    logic            inj_en = 1'b0;
    logic [N-1:0]    inj_v  = '0;
    logic [N*FW-1:0] inj_d  = '0;
    logic [N-1:0]    bp_ok  = 4'hF;
    logic [N-1:0]    lock_v = '0;
    logic [1:0]      lock_s [N];
    logic [1:0]      sel_s  [N];
    logic [N-1:0]    fwd;

    initial for (int j = 0; j < N; j++) lock_s[j] = 2'd0;

    always @(posedge clk) begin
        #2;
        bp_ok = bp_en ? 4'($urandom) : 4'hF;
    end

    always_comb begin
        logic       found;
        logic [1:0] s;
        tx_ready = '0;
        rx_valid = '0;
        rx_data  = '0;
        fwd      = '0;
        for (int j = 0; j < N; j++) sel_s[j] = lock_s[j];
        if (inj_en) begin
            rx_valid = inj_v;
            rx_data  = inj_d;
        end else if (net_en) begin
            for (int j = 0; j < N; j++) begin
                found = lock_v[j];
                s     = lock_s[j];
                for (int k = 0; k < N; k++) begin
                    if (!found && tx_valid[k] && tx_data[k*FW+27 +: 2] == 2'(j)) begin
                        found = 1'b1;
                        s     = 2'(k);
                    end
                end
                if (found && tx_valid[s] && bp_ok[s]) begin
                    fwd[j]   = 1'b1;
                    sel_s[j] = s;
                    tx_ready[s] = 1'b1;
                    rx_valid[j] = 1'b1;
                    rx_data[j*FW +: FW] = tx_data[s*FW +: FW];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            lock_v <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (fwd[j]) begin
                    lock_v[j] <= !rx_data[j*FW+31];
                    lock_s[j] <= sel_s[j];
                end
            end
        end
    end

    // Bookkeeping
    int           tests = 0;
    int           fails = 0;
    int           sb [N][N];
    int           stalls, viol;
    logic [N-1:0] hold_q = '0;
    logic [FW-1:0] hold_d [N];

    typedef struct {
        logic [1:0] mode;
        logic [1:0] fdst;
        logic [7:0] gap;
        bit         bp;
        bit         chk_fixed;
        int         exp_done;
        int         exp_err;
        int         exp_tx;
        int         exp_rx;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int j = 0; j < N; j++) begin
            if (rx_valid[j] && rx_data[j*FW+31]) sb[j][rx_data[j*FW+29 +: 2]]++;
            if (hold_q[j]) begin
                stalls++;
                if (!tx_valid[j] || tx_data[j*FW +: FW] != hold_d[j]) viol++;
            end
            hold_q[j] = rst && tx_valid[j] && !tx_ready[j];
            hold_d[j] = tx_data[j*FW +: FW];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v, input string tag);
        int cyc;
        int other;
        mode = v.mode; fixed_dst = v.fdst; inj_gap = v.gap;
        bp_en = v.bp; net_en = 1'b1; inj_en = 1'b0;
        for (int a = 0; a < N; a++) for (int b = 0; b < N; b++) sb[a][b] = 0;
        stalls = 0; viol = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s busy_set", tag), int'(busy), 1);
        chk($sformatf("%s done_clr", tag), int'(done), 0);
        cyc = 1;
        while (busy && cyc < 4000) begin
            tick();
            cyc++;
        end
        chk($sformatf("%s finished", tag), int'(busy), 0);
        chk($sformatf("%s done", tag), int'(done), v.exp_done);
        chk($sformatf("%s err", tag), int'(err), v.exp_err);
        chk($sformatf("%s tx_pkts", tag), int'(tx_pkts), v.exp_tx);
        chk($sformatf("%s rx_pkts", tag), int'(rx_pkts), v.exp_rx);
        chk($sformatf("%s busy_ge_64", tag), int'(cyc >= 64), 1);
        chk($sformatf("%s stall_stable", tag), viol, 0);
        if (v.bp) chk($sformatf("%s stalls_seen", tag), int'(stalls > 0), 1);
        if (v.chk_fixed) begin
            other = 0;
            for (int s = 0; s < N; s++) begin
                chk($sformatf("%s node2_from_src%0d", tag, s), sb[2][s], 16);
                for (int d = 0; d < N; d++) if (d != 2) other += sb[d][s];
            end
            chk($sformatf("%s other_nodes", tag), other, 0);
        end
    endtask

    initial begin
        int cnt;
        vecs[0] = '{mode: 2'd2, fdst: 2'd0, gap: 8'd0, bp: 1'b0, chk_fixed: 1'b0, exp_done: 1, exp_err: 0, exp_tx: 64, exp_rx: 64};
        vecs[1] = '{mode: 2'd2, fdst: 2'd0, gap: 8'd0, bp: 1'b1, chk_fixed: 1'b0, exp_done: 1, exp_err: 0, exp_tx: 64, exp_rx: 64};
        vecs[2] = '{mode: 2'd1, fdst: 2'd2, gap: 8'd1, bp: 1'b0, chk_fixed: 1'b1, exp_done: 1, exp_err: 0, exp_tx: 64, exp_rx: 64};
        vecs[3] = '{mode: 2'd0, fdst: 2'd0, gap: 8'd3, bp: 1'b1, chk_fixed: 1'b0, exp_done: 1, exp_err: 0, exp_tx: 64, exp_rx: 64};
        vecs[4] = '{mode: 2'd3, fdst: 2'd1, gap: 8'd0, bp: 1'b0, chk_fixed: 1'b0, exp_done: 1, exp_err: 0, exp_tx: 64, exp_rx: 64};

        // Reset state, start during reset ignored
        rst = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst rx_ready", int'(rx_ready), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst tx_valid", int'(tx_valid), 0);
        chk("rst tx_pkts", int'(tx_pkts), 0);
        rst = 1'b1;
        tick();
        chk("post_rst rx_ready", int'(rx_ready), 15);
        chk("post_rst busy", int'(busy), 0);

        for (int v = 0; v < 5; v++) run(vecs[v], $sformatf("vec%0d", v));

        // Misrouted flit at node 1 addressed to node 3
        repeat (2) tick();
        mode = 2'd2; inj_gap = 8'd0; net_en = 1'b0; bp_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("misroute pre_err", int'(err), 0);
        inj_d = '0;
        inj_d[1*FW +: FW] = {1'b0, 2'd0, 2'd3, 8'd0, 19'd0};
        inj_v = 4'b0010;
        inj_en = 1'b1;
        tick();
        inj_en = 1'b0;
        inj_v = '0;
        chk("misroute err", int'(err), 1);
        chk("misroute busy", int'(busy), 0);
        chk("misroute done", int'(done), 0);

        // Timeout with no ejected traffic
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("timeout err_cleared", int'(err), 0);
        cnt = 1;
        while (!err && cnt < 5000) begin
            tick();
            cnt++;
        end
        tests++;
        if (cnt < 4095 || cnt > 4097) begin
            fails++;
            $display("FAIL timeout_cycle: err after %0d cycles, expected 4096 +-1", cnt);
        end
        chk("timeout busy", int'(busy), 0);
        chk("timeout done", int'(done), 0);

        // Reset in the middle of a run, then a clean rerun
        mode = 2'd2; inj_gap = 8'd0; net_en = 1'b1; bp_en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        while ((tx_pkts < 16'd4 || tx_valid == '0) && cnt < 500) begin
            tick();
            cnt++;
        end
        chk("midrst in_send", int'(tx_valid != '0), 1);
        rst = 1'b0;
        tick();
        chk("midrst tx_valid", int'(tx_valid), 0);
        chk("midrst tx_pkts", int'(tx_pkts), 0);
        chk("midrst rx_pkts", int'(rx_pkts), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst rx_ready", int'(rx_ready), 0);
        rst = 1'b1;
        tick();
        run(vecs[1], "rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
